// File: rtl/riscv_pkg.sv
// Shared RV32I controller types: opcode encodings and datapath mux encodings.
package riscv_pkg;

  // Major opcodes decoded by the multicycle main controller
  typedef enum logic [6:0] {
    OP_L     = 7'b0000011,
    OP_I     = 7'b0010011,
    OP_AUIPC = 7'b0010111,
    OP_S     = 7'b0100011,
    OP_R     = 7'b0110011,
    OP_LUI   = 7'b0110111,
    OP_B     = 7'b1100011,
    OP_JALR  = 7'b1100111,
    OP_JAL   = 7'b1101111
  } opcode_e;

  // ResultSrc select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALUSrcB select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

endpackage : riscv_pkg

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter: clears on request, counts stalled cycles,
// flags when the stall count has reached the timeout limit.
module mem_wait_timer #(
  parameter int unsigned TO_W   = 4,
  parameter int unsigned MEM_TO = 15
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_c
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Clear has priority over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == TO_W'(MEM_TO));

endmodule : mem_wait_timer

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I main control FSM with memory wait-state handshake,
// illegal-opcode trap and memory-timeout fault.
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module mc_ctrl_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned TO_W   = 4,
  parameter int unsigned MEM_TO = 15
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  opcode_e    opcode_i,
  input  logic       Zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       Branch_o,
  output logic       PCUpdate_o,
  output logic       PCWrite_o,
  output logic       RegWrite_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic       AdrSrc_o,
  output logic       illegal_o,
  output logic       mem_fault_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JALRADR,
    S_JAL,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   illegal_q;
  logic   illegal_d;
  logic   mem_fault_q;
  logic   mem_fault_d;
  logic   mem_state_c;
  logic   expire_c;

  assign mem_state_c = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);

  // Wait counter restarts on every state change, so each memory state is entered with zero
  mem_wait_timer #(
    .TO_W   (TO_W),
    .MEM_TO (MEM_TO)
  ) u_wait_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (state_d != state_q),
    .inc_i    (mem_state_c && !mem_ready_i),
    .expire_c (expire_c)
  );

  // State and sticky flag registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_FETCH;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Next-state logic; a ready in the expiry cycle still completes the access
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    mem_fault_d = mem_fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (expire_c) begin
          state_d     = S_TRAP;
          mem_fault_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode_i)
          OP_L, OP_S: state_d = S_MEMADR;
          OP_R:       state_d = S_EXECR;
          OP_I:       state_d = S_EXECI;
          OP_B:       state_d = S_BEQ;
          OP_JAL:     state_d = S_JAL;
          OP_JALR:    state_d = S_JALRADR;
          OP_LUI:     state_d = S_LUI;
          OP_AUIPC:   state_d = S_AUIPC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (opcode_i == OP_S) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready_i) begin
          state_d = S_MEMWB;
        end else if (expire_c) begin
          state_d     = S_TRAP;
          mem_fault_d = 1'b1;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready_i) begin
          state_d = S_FETCH;
        end else if (expire_c) begin
          state_d     = S_TRAP;
          mem_fault_d = 1'b1;
        end
      end
      S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALRADR:                               state_d = S_JAL;
      S_ALUWB, S_MEMWB, S_BEQ:                 state_d = S_FETCH;
      S_TRAP:                                  state_d = S_TRAP;
      default:                                 state_d = S_FETCH;
    endcase
  end

  // Moore datapath controls; handshake-qualified enables in memory states
  always_comb begin
    mem_req_o   = 1'b0;
    Branch_o    = 1'b0;
    PCUpdate_o  = 1'b0;
    RegWrite_o  = 1'b0;
    MemWrite_o  = 1'b0;
    IRWrite_o   = 1'b0;
    AdrSrc_o    = ADR_PC;
    ResultSrc_o = RES_ALUOUT;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RD2;
    ALUOp_o     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        AdrSrc_o    = ADR_PC;
        ALUSrcA_o   = SRCA_PC;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        IRWrite_o   = mem_ready_i;
        PCUpdate_o  = mem_ready_i;
      end
      S_DECODE, S_AUIPC: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = ALUOP_ADD;
      end
      S_MEMADR, S_JALRADR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        AdrSrc_o  = ADR_ALUOUT;
      end
      S_MEMWB: begin
        ResultSrc_o = RES_DATA;
        RegWrite_o  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o  = 1'b1;
        AdrSrc_o   = ADR_ALUOUT;
        MemWrite_o = mem_ready_i;
      end
      S_EXECR: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_RD2;
        ALUOp_o   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA_o = SRCA_RD1;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc_o = RES_ALUOUT;
        RegWrite_o  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA_o   = SRCA_RD1;
        ALUSrcB_o   = SRCB_RD2;
        ALUOp_o     = ALUOP_SUB;
        ResultSrc_o = RES_ALUOUT;
        Branch_o    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA_o   = SRCA_OLDPC;
        ALUSrcB_o   = SRCB_FOUR;
        ALUOp_o     = ALUOP_ADD;
        ResultSrc_o = RES_ALUOUT;
        PCUpdate_o  = 1'b1;
      end
      S_LUI: begin
        ALUSrcA_o = SRCA_ZERO;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = ALUOP_ADD;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  assign PCWrite_o   = PCUpdate_o | (Branch_o & Zero_i);
  assign illegal_o   = illegal_q;
  assign mem_fault_o = mem_fault_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             retire_c;

  // Cycle count runs outside TRAP; an instruction retires when it hands back to FETCH
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    retire_c    = (state_d == S_FETCH) &&
                  ((state_q == S_ALUWB) || (state_q == S_MEMWB) ||
                   (state_q == S_MEMWRITE) || (state_q == S_BEQ));
    if (state_q != S_TRAP) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
    if (retire_c) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule : mc_ctrl_fsm

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (default parameters).
module tb_mc_ctrl_fsm;
  import riscv_pkg::*;

  // Control vector: mem_req, Branch, PCUpdate, RegWrite, MemWrite, IRWrite,
  // AdrSrc, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0]
  localparam logic [14:0] C_FETCH0  = 15'b1_0_0_0_0_0_0_10_00_10_00;
  localparam logic [14:0] C_FETCH1  = 15'b1_0_1_0_0_1_0_10_00_10_00;
  localparam logic [14:0] C_DECODE  = 15'b0_0_0_0_0_0_0_00_01_01_00;
  localparam logic [14:0] C_MEMADR  = 15'b0_0_0_0_0_0_0_00_10_01_00;
  localparam logic [14:0] C_MEMRD   = 15'b1_0_0_0_0_0_1_00_00_00_00;
  localparam logic [14:0] C_MEMWB   = 15'b0_0_0_1_0_0_0_01_00_00_00;
  localparam logic [14:0] C_MEMWR0  = 15'b1_0_0_0_0_0_1_00_00_00_00;
  localparam logic [14:0] C_MEMWR1  = 15'b1_0_0_0_1_0_1_00_00_00_00;
  localparam logic [14:0] C_EXECR   = 15'b0_0_0_0_0_0_0_00_10_00_10;
  localparam logic [14:0] C_EXECI   = 15'b0_0_0_0_0_0_0_00_10_01_10;
  localparam logic [14:0] C_ALUWB   = 15'b0_0_0_1_0_0_0_00_00_00_00;
  localparam logic [14:0] C_BEQ     = 15'b0_1_0_0_0_0_0_00_10_00_01;
  localparam logic [14:0] C_JALRADR = 15'b0_0_0_0_0_0_0_00_10_01_00;
  localparam logic [14:0] C_JAL     = 15'b0_0_1_0_0_0_0_00_01_10_00;
  localparam logic [14:0] C_LUI     = 15'b0_0_0_0_0_0_0_00_11_01_00;
  localparam logic [14:0] C_AUIPC   = 15'b0_0_0_0_0_0_0_00_01_01_00;
  localparam logic [14:0] C_TRAP    = 15'b0;

  logic       clk;
  logic       rstn;
  opcode_e    opcode;
  logic       zero;
  logic       ready;
  logic       mem_req, branch, pcupdate, pcwrite, regwrite, memwrite, irwrite;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       adr_src, illegal, mem_fault;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret;
`endif
  logic [14:0] ctl;

  int total;
  int bad;

  mc_ctrl_fsm dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .opcode_i    (opcode),
    .Zero_i      (zero),
    .mem_ready_i (ready),
    .mem_req_o   (mem_req),
    .Branch_o    (branch),
    .PCUpdate_o  (pcupdate),
    .PCWrite_o   (pcwrite),
    .RegWrite_o  (regwrite),
    .MemWrite_o  (memwrite),
    .IRWrite_o   (irwrite),
    .ResultSrc_o (result_src),
    .ALUSrcA_o   (alu_src_a),
    .ALUSrcB_o   (alu_src_b),
    .ALUOp_o     (alu_op),
    .AdrSrc_o    (adr_src),
    .illegal_o   (illegal),
    .mem_fault_o (mem_fault)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt_o (cycle_cnt),
    .instret_o   (instret)
`endif
  );

  assign ctl = {mem_req, branch, pcupdate, regwrite, memwrite, irwrite, adr_src,
                result_src, alu_src_a, alu_src_b, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ready = 1'b0; zero = 1'b0; opcode = OP_R;
    tick(); tick();
    total++;
    if (ctl !== C_FETCH0) begin bad++; $display("FAIL reset_ctl got=%h want=%h", ctl, C_FETCH0); end
    total++;
    if ({illegal, mem_fault, pcwrite} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {illegal, mem_fault, pcwrite});
    end
`ifdef CTRL_PERF_CNT_EN
    total++;
    if ({cycle_cnt, instret} !== 64'd0) begin bad++; $display("FAIL reset_perf got=%h want=0", {cycle_cnt, instret}); end
`endif
    rstn = 1'b1;
  endtask

  task automatic test_lw();
    logic [14:0] ex [6] = '{C_FETCH1, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH0};
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] c0, r0;
    c0 = cycle_cnt; r0 = instret;
`endif
    opcode = OP_L;
    for (int i = 0; i < 6; i++) begin
      ready = (i < 5);
      #1;
`ifdef CTRL_PERF_CNT_EN
      if (i == 5) begin
        total++;
        if (cycle_cnt - c0 !== 32'd5) begin bad++; $display("FAIL lw_cycles got=%0d want=5", cycle_cnt - c0); end
        total++;
        if (instret - r0 !== 32'd1) begin bad++; $display("FAIL lw_instret got=%0d want=1", instret - r0); end
      end
`endif
      total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL lw_cyc%0d got=%h want=%h", i, ctl, ex[i]); end
      tick();
    end
  endtask

  task automatic test_sw_wait();
    logic [14:0] ex [8] = '{C_FETCH1, C_DECODE, C_MEMADR, C_MEMWR0, C_MEMWR0, C_MEMWR0, C_MEMWR1, C_FETCH0};
    bit rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = OP_S;
    for (int i = 0; i < 8; i++) begin
      ready = rd[i];
      #1;
      total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL sw_cyc%0d got=%h want=%h", i, ctl, ex[i]); end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [14:0] ex [4] = '{C_FETCH1, C_DECODE, C_BEQ, C_FETCH0};
    opcode = OP_B;
    for (int z = 0; z < 2; z++) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        ready = (i < 2);
        #1;
        total++;
        if (ctl !== ex[i]) begin bad++; $display("FAIL beq_z%0d_cyc%0d got=%h want=%h", z, i, ctl, ex[i]); end
        if (i == 2) begin
          total++;
          if (pcwrite !== z[0]) begin bad++; $display("FAIL beq_pcwrite_z%0d got=%b want=%b", z, pcwrite, z[0]); end
        end
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jalr();
    logic [14:0] ex [6] = '{C_FETCH1, C_DECODE, C_JALRADR, C_JAL, C_ALUWB, C_FETCH0};
    bit pw [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    opcode = OP_JALR;
    zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ready = (i == 0);
      #1;
      total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL jalr_cyc%0d got=%h want=%h", i, ctl, ex[i]); end
      total++;
      if (pcwrite !== pw[i]) begin bad++; $display("FAIL jalr_pcwrite_cyc%0d got=%b want=%b", i, pcwrite, pw[i]); end
      tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_alu_ops();
    opcode_e     ops  [5] = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL};
    logic [14:0] mids [5] = '{C_EXECR, C_EXECI, C_LUI, C_AUIPC, C_JAL};
    logic [14:0] ex   [5];
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k];
      ex = '{C_FETCH1, C_DECODE, mids[k], C_ALUWB, C_FETCH0};
      for (int i = 0; i < 5; i++) begin
        ready = (i < 4);
        #1;
        total++;
        if (ctl !== ex[i]) begin bad++; $display("FAIL alu_op%0d_cyc%0d got=%h want=%h", k, i, ctl, ex[i]); end
        tick();
      end
    end
  endtask

  task automatic test_illegal();
    opcode = opcode_e'(7'h7F);
    ready = 1'b1;
    #1;
    total++;
    if (ctl !== C_FETCH1) begin bad++; $display("FAIL ill_fetch got=%h want=%h", ctl, C_FETCH1); end
    tick();
    total++;
    if ({ctl, illegal} !== {C_DECODE, 1'b0}) begin bad++; $display("FAIL ill_decode got=%h/%b want=%h/0", ctl, illegal, C_DECODE); end
    tick();
    for (int i = 0; i < 20; i++) begin
      ready = i[0];
      #1;
      total++;
      if ({ctl, illegal, mem_fault} !== {C_TRAP, 2'b10}) begin
        bad++; $display("FAIL ill_trap_cyc%0d got=%h/%b/%b want=%h/1/0", i, ctl, illegal, mem_fault, C_TRAP);
      end
      tick();
    end
    ready = 1'b0;
    rstn  = 1'b0;
    #1;
    total++;
    if ({ctl, illegal} !== {C_FETCH0, 1'b0}) begin bad++; $display("FAIL ill_reset got=%h/%b want=%h/0", ctl, illegal, C_FETCH0); end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid();
    opcode = OP_S;
    ready = 1'b1;
    tick(); tick();
    #1;
    total++;
    if (ctl !== C_MEMADR) begin bad++; $display("FAIL mid_memadr got=%h want=%h", ctl, C_MEMADR); end
    ready = 1'b0;
    rstn  = 1'b0;
    #1;
    total++;
    if (ctl !== C_FETCH0) begin bad++; $display("FAIL mid_reset got=%h want=%h", ctl, C_FETCH0); end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ready = 1'b1;
      #1;
      total++;
      if (ctl !== C_FETCH1) begin bad++; $display("FAIL mid_after_cyc%0d got=%h want=%h", i, ctl, C_FETCH1); end
      ready = 1'b0;
      #1;
      total++;
      if ({regwrite, memwrite} !== 2'b00) begin bad++; $display("FAIL mid_nowrite_cyc%0d got=%b want=00", i, {regwrite, memwrite}); end
      tick();
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    opcode = OP_I;
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if ({ctl, mem_fault} !== {C_FETCH0, 1'b0}) begin bad++; $display("FAIL to_wait_cyc%0d got=%h/%b want=%h/0", i, ctl, mem_fault, C_FETCH0); end
      tick();
    end
    total++;
    if ({ctl, mem_fault, illegal} !== {C_TRAP, 2'b10}) begin
      bad++; $display("FAIL to_trap got=%h/%b/%b want=%h/1/0", ctl, mem_fault, illegal, C_TRAP);
    end
    ready = 1'b1;
    tick();
    total++;
    if ({ctl, mem_fault} !== {C_TRAP, 1'b1}) begin bad++; $display("FAIL to_hold got=%h/%b want=%h/1", ctl, mem_fault, C_TRAP); end
    pulse_reset();
    total++;
    if (mem_fault !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", mem_fault); end
  endtask

  task automatic test_timeout_edge();
    logic [14:0] ex [4] = '{C_DECODE, C_EXECI, C_ALUWB, C_FETCH0};
    pulse_reset();
    opcode = OP_I;
    ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    ready = 1'b1;
    #1;
    total++;
    if (ctl !== C_FETCH1) begin bad++; $display("FAIL toe_ready got=%h want=%h", ctl, C_FETCH1); end
    tick();
    for (int i = 0; i < 4; i++) begin
      ready = 1'b0;
      #1;
      total++;
      if ({ctl, mem_fault} !== {ex[i], 1'b0}) begin bad++; $display("FAIL toe_cyc%0d got=%h/%b want=%h/0", i, ctl, mem_fault, ex[i]); end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    tick();
    test_lw();
    test_sw_wait();
    test_beq();
    test_jalr();
    test_alu_ops();
    test_illegal();
    test_reset_mid();
    test_timeout();
    test_timeout_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mc_ctrl_fsm

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle RV32I main control FSM with memory wait-state handshake, extended opcode coverage (JALR, LUI, AUIPC), illegal-opcode trap and memory-timeout fault. It sits in the controller next to the ALU decoder and drives the multicycle datapath muxes and enables. Unlike the single-cycle-memory main FSM, it holds fetch and memory states until the memory acknowledges.

## Interface
- `TO_W`, default 4: width of the memory wait counter.
- `MEM_TO`, default 15: maximum wait cycles per memory access before fault; must be less than 2^TO_W.
- `CNT_W`, default 32: width of the performance counters.
- `clk_i` input 1: clock, rising edge.
- `rstn_i` input 1: asynchronous active-low reset.
- `opcode_i` input opcode_e: opcode field of the instruction register.
- `Zero_i` input 1: ALU zero flag.
- `mem_ready_i` input 1: memory completes the current access this cycle.
- `mem_req_o` output 1: memory access request.
- `Branch_o`, `PCUpdate_o`, `PCWrite_o`, `RegWrite_o`, `MemWrite_o`, `IRWrite_o` output 1: datapath enables.
- `ResultSrc_o`, `ALUSrcA_o`, `ALUSrcB_o`, `ALUOp_o` output 2: mux selects and ALU operation class.
- `AdrSrc_o` output 1: 0 = PC, 1 = ALUOut.
- `illegal_o` output 1: sticky illegal-opcode flag.
- `mem_fault_o` output 1: sticky memory-timeout flag.
- `cycle_cnt_o`, `instret_o` output CNT_W: performance counters (only with `CTRL_PERF_CNT_EN`).

## Operation
- Encodings:
  - ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
  - ALUSrcA: 00 PC, 01 OldPC, 10 RD1, 11 zero.
  - ALUSrcB: 00 RD2, 01 ImmExt, 10 const 4.
  - ALUOp: 00 add, 01 sub, 10 funct decode.
- Moore outputs. All signals not listed for a state are 0.
- States and per-state outputs:
  - S_FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCUpdate are asserted only when mem_ready_i=1.
  - S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - S_MEMREAD: mem_req, AdrSrc=1.
  - S_MEMWB: ResultSrc=01, RegWrite.
  - S_MEMWRITE: mem_req, AdrSrc=1. MemWrite is asserted only when mem_ready_i=1.
  - S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - S_ALUWB: ResultSrc=00, RegWrite.
  - S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch.
  - S_JALRADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate.
  - S_LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00.
  - S_AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - S_TRAP: all outputs 0.
- Transitions:
  - FETCH → DECODE on mem_ready_i, else stay.
  - DECODE by opcode:
    - L and S → MEMADR
    - R → EXECR
    - I → EXECI
    - B → BEQ
    - JAL → JAL
    - JALR → JALRADR
    - LUI → LUI
    - AUIPC → AUIPC
    - any other value → TRAP, setting illegal_o.
  - MEMADR → MEMREAD if opcode is L, MEMWRITE if S.
  - MEMREAD → MEMWB on mem_ready_i.
  - MEMWRITE → FETCH on mem_ready_i.
  - EXECR, EXECI, JAL, LUI, AUIPC → ALUWB.
  - JALRADR → JAL.
  - ALUWB, MEMWB, BEQ → FETCH.
  - TRAP → TRAP until reset.
- `PCWrite_o` = PCUpdate_o | (Branch_o & Zero_i), combinational.
- Wait counter:
  - Cleared on entry to any memory state (FETCH, MEMREAD, MEMWRITE).
  - Increments each cycle the FSM is in a memory state with mem_ready_i=0.
  - When the counter equals MEM_TO with mem_ready_i=0 → TRAP and set mem_fault_o.
  - mem_ready_i=1 in the same cycle as the count reaching MEM_TO: the access completes and no fault is raised.
- mem_ready_i is ignored outside memory states.

## Timing
- Reset: state S_FETCH; wait counter, illegal_o, mem_fault_o and counters all 0. Outputs take S_FETCH values.
- Reset mid-instruction aborts it. Next state is FETCH, and no RegWrite or MemWrite is issued after reset deassertion until a new instruction is reached.
- Latencies with zero wait states:
  - lw: 5 cycles
  - sw: 4
  - R / I / LUI / AUIPC: 4
  - beq: 3
  - jal: 4
  - jalr: 5
- Each wait cycle adds one cycle to the access.
- Sticky flags are set on the edge that enters TRAP.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - cycle_cnt_o increments every cycle outside TRAP.
  - instret_o increments on every transition into FETCH from ALUWB, MEMWB, MEMWRITE or BEQ.
  - Both counters wrap modulo 2^CNT_W.
- `CTRL_PERF_CNT_EN` undefined: both counter ports and their logic are absent.

## Structure
- `riscv_pkg` holds `opcode_e`, which gains OP_JALR, OP_LUI and OP_AUIPC, plus the mux encoding localparams.
- FSM state enum stays local to the module.
- One sub-module, `mem_wait_timer`: counter, clear, expire output, parametrised by TO_W and MEM_TO.

## Test plan
- lw with mem_ready_i tied 1 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite_o=1 with ResultSrc_o=01 in cycle 5.
- sw with mem_ready_i delayed 3 cycles in MEMWRITE → MemWrite_o pulses once, in the ready cycle; total 7 cycles.
- beq: Zero_i=1 → PCWrite_o=1 in BEQ; Zero_i=0 → PCWrite_o=0; both cases return to FETCH.
- jalr → JALRADR, JAL, ALUWB; PCUpdate_o=1 only in JAL; RegWrite_o=1 only in ALUWB.
- opcode 7'h7F in DECODE → TRAP and illegal_o=1; holds for 20 cycles; rstn_i low for 1 cycle → FETCH with illegal_o=0.
- mem_ready_i held 0 in FETCH (MEM_TO=15) → TRAP after 15 wait cycles with mem_fault_o=1; repeat with ready arriving at cycle 15 → no fault.
